// File: rtl/microcode_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with an absorbing TRAP
// state for illegal micro-ops, plus a retired-instruction counter.
module microcode_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  uop_addr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_write,
  output logic        alu_en,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [5:0]  uop_q,
  output logic [2:0]  state_q,
  output logic        trap,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_e;

  localparam logic [5:0] UOP_NOP    = 6'd0;
  localparam logic [5:0] UOP_LOAD   = 6'd11;
  localparam logic [5:0] UOP_STORE  = 6'd12;
  localparam logic [5:0] UOP_BRANCH = 6'd13;
  localparam logic [5:0] UOP_JAL    = 6'd25;
  localparam logic [5:0] UOP_JALR   = 6'd26;
  localparam logic [5:0] UOP_LAST   = 6'd26;

  state_e      st_q, st_d;
  logic [5:0]  uop_d;
  logic        br_q, br_d;
  logic [31:0] instret_q, instret_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= S_FETCH;
      uop_q     <= 6'd0;
      br_q      <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      st_q      <= st_d;
      uop_q     <= uop_d;
      br_q      <= br_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    uop_d     = uop_q;
    br_d      = br_q;
    instret_d = instret_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    alu_en    = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;

    unique case (st_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          st_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        uop_d = uop_addr;
        br_d  = 1'b0;
        st_d  = (uop_addr > UOP_LAST) ? S_TRAP : S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_en = 1'b1;
        if (uop_q == UOP_BRANCH) br_d = branch_taken;
        st_d = (uop_q == UOP_LOAD || uop_q == UOP_STORE) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = (uop_q == UOP_STORE);
        if (dmem_ready) st_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        pc_write  = 1'b1;
        reg_we    = !(uop_q == UOP_NOP || uop_q == UOP_STORE || uop_q == UOP_BRANCH);
        instret_d = instret_q + 32'd1;
        st_d      = S_FETCH;
        if (uop_q == UOP_BRANCH && br_q) pc_src = 2'd1;
        else if (uop_q == UOP_JAL)       pc_src = 2'd2;
        else if (uop_q == UOP_JALR)      pc_src = 2'd3;
      end
      S_TRAP: st_d = S_TRAP;
      default: st_d = S_FETCH;
    endcase

    // The register state already reads FETCH during reset; this keeps imem_req low as well.
    if (reset) begin
      imem_req = 1'b0;
      ir_write = 1'b0;
      alu_en   = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      reg_we   = 1'b0;
      pc_write = 1'b0;
      pc_src   = 2'd0;
    end
  end

  assign state_q = st_q;
  assign trap    = (st_q == S_TRAP);
  assign instret = instret_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed self-checking bench for microcode_sequencer: one task per scenario, inline checks.
module tb_microcode_sequencer;

  logic        clk;
  logic        reset;
  logic [5:0]  uop_addr;
  logic        imem_ready;
  logic        dmem_ready;
  logic        branch_taken;
  logic        imem_req;
  logic        ir_write;
  logic        alu_en;
  logic        dmem_req;
  logic        dmem_we;
  logic        reg_we;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [5:0]  uop_q;
  logic [2:0]  state_q;
  logic        trap;
  logic [31:0] instret;

  microcode_sequencer dut (
    .clk(clk), .reset(reset), .uop_addr(uop_addr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken), .imem_req(imem_req),
    .ir_write(ir_write), .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .pc_write(pc_write), .pc_src(pc_src), .uop_q(uop_q),
    .state_q(state_q), .trap(trap), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_instret = 0;

  int n_cyc;
  int cnt_imem, cnt_ir, cnt_alu, cnt_dreq, cnt_dwe, cnt_pcw, cnt_regwe;
  logic       wb_reg_we;
  logic [1:0] wb_pc_src;
  logic [2:0] trace [0:63];

  // Runs one instruction from an aligned FETCH (just after a rising edge) until WRITEBACK retires.
  task automatic run_instr(input logic [5:0] uop, input int iw, input int dw, input logic bt);
    int fc, mc;
    logic [2:0] s;
    n_cyc = 0; fc = 0; mc = 0;
    cnt_imem = 0; cnt_ir = 0; cnt_alu = 0; cnt_dreq = 0; cnt_dwe = 0; cnt_pcw = 0; cnt_regwe = 0;
    wb_reg_we = 1'bx; wb_pc_src = 2'bxx;
    uop_addr = uop; branch_taken = bt;
    while (n_cyc < 40) begin
      s = state_q;
      imem_ready = (s == 3'd0) ? (fc >= iw) : 1'b1;
      dmem_ready = (s == 3'd3) ? (mc >= dw) : 1'b1;
      if (s == 3'd0) fc++;
      if (s == 3'd3) mc++;
      @(negedge clk);
      trace[n_cyc] = state_q;
      if (imem_req) cnt_imem++;
      if (ir_write) cnt_ir++;
      if (alu_en)   cnt_alu++;
      if (dmem_req) cnt_dreq++;
      if (dmem_we)  cnt_dwe++;
      if (pc_write) cnt_pcw++;
      if (reg_we)   cnt_regwe++;
      if (state_q == 3'd4) begin
        wb_reg_we = reg_we;
        wb_pc_src = pc_src;
      end
      @(posedge clk); #1;
      n_cyc++;
      if (s == 3'd4) break;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    exp_instret++;
    $display("[TB] uop=%0d iw=%0d dw=%0d bt=%0d cycles=%0d reg_we=%0b pc_src=%0d instret=%0d",
             uop, iw, dw, bt, n_cyc, wb_reg_we, wb_pc_src, instret);
  endtask

  task automatic test_reset();
    reset = 1'b1; uop_addr = 6'd0; imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b0;
    #2;
    tests++;
    if (state_q !== 3'd0 || uop_q !== 6'd0 || trap !== 1'b0 || instret !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: state=%0d uop=%0d trap=%0b instret=%0d, required 0/0/0/0",
               state_q, uop_q, trap, instret);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({imem_req, ir_write, alu_en, dmem_req, dmem_we, reg_we, pc_write} !== 7'b0) begin
      fails++;
      $display("FAIL reset_strobes: strobes=%b, required 0000000",
               {imem_req, ir_write, alu_en, dmem_req, dmem_we, reg_we, pc_write});
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || state_q !== 3'd0) begin
      fails++;
      $display("FAIL reset_release: imem_req=%0b state=%0d, required 1/0", imem_req, state_q);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    run_instr(6'd1, 0, 0, 1'b0);
    tests++;
    if (n_cyc !== 4 || {trace[0], trace[1], trace[2], trace[3]} !== 12'o0124) begin
      fails++;
      $display("FAIL add_sequence: cycles=%0d states=%0d,%0d,%0d,%0d, required 4 cycles 0,1,2,4",
               n_cyc, trace[0], trace[1], trace[2], trace[3]);
    end
    tests++;
    if (wb_reg_we !== 1'b1 || wb_pc_src !== 2'd0 || cnt_alu !== 1 || cnt_pcw !== 1 || cnt_ir !== 1) begin
      fails++;
      $display("FAIL add_strobes: reg_we=%0b pc_src=%0d alu=%0d pcw=%0d ir=%0d, required 1/0/1/1/1",
               wb_reg_we, wb_pc_src, cnt_alu, cnt_pcw, cnt_ir);
    end
    tests++;
    if (instret !== 32'd1 || state_q !== 3'd0) begin
      fails++;
      $display("FAIL add_instret: instret=%0d state=%0d, required 1/0", instret, state_q);
    end
  endtask

  task automatic test_load_wait();
    run_instr(6'd11, 0, 3, 1'b0);
    tests++;
    if (n_cyc !== 8 || cnt_dreq !== 4 || cnt_dwe !== 0) begin
      fails++;
      $display("FAIL load_wait: cycles=%0d dmem_req=%0d dmem_we=%0d, required 8/4/0",
               n_cyc, cnt_dreq, cnt_dwe);
    end
    tests++;
    if (wb_reg_we !== 1'b1 || wb_pc_src !== 2'd0 || cnt_regwe !== 1 || instret !== exp_instret) begin
      fails++;
      $display("FAIL load_wb: reg_we=%0b pc_src=%0d regwe_cnt=%0d instret=%0d, required 1/0/1/%0d",
               wb_reg_we, wb_pc_src, cnt_regwe, instret, exp_instret);
    end
  endtask

  task automatic test_store();
    run_instr(6'd12, 0, 1, 1'b0);
    tests++;
    if (n_cyc !== 6 || cnt_dreq !== 2 || cnt_dwe !== 2) begin
      fails++;
      $display("FAIL store_mem: cycles=%0d dmem_req=%0d dmem_we=%0d, required 6/2/2",
               n_cyc, cnt_dreq, cnt_dwe);
    end
    tests++;
    if (wb_reg_we !== 1'b0 || wb_pc_src !== 2'd0 || cnt_pcw !== 1) begin
      fails++;
      $display("FAIL store_wb: reg_we=%0b pc_src=%0d pcw=%0d, required 0/0/1",
               wb_reg_we, wb_pc_src, cnt_pcw);
    end
  endtask

  task automatic test_branch();
    run_instr(6'd13, 0, 0, 1'b1);
    tests++;
    if (wb_pc_src !== 2'd1 || wb_reg_we !== 1'b0 || n_cyc !== 4) begin
      fails++;
      $display("FAIL branch_taken: pc_src=%0d reg_we=%0b cycles=%0d, required 1/0/4",
               wb_pc_src, wb_reg_we, n_cyc);
    end
    run_instr(6'd13, 0, 0, 1'b0);
    tests++;
    if (wb_pc_src !== 2'd0 || wb_reg_we !== 1'b0) begin
      fails++;
      $display("FAIL branch_not_taken: pc_src=%0d reg_we=%0b, required 0/0", wb_pc_src, wb_reg_we);
    end
    // A taken condition on a non-branch op must not redirect the PC.
    run_instr(6'd14, 0, 0, 1'b1);
    tests++;
    if (wb_pc_src !== 2'd0 || wb_reg_we !== 1'b1) begin
      fails++;
      $display("FAIL nonbranch_bt: pc_src=%0d reg_we=%0b, required 0/1", wb_pc_src, wb_reg_we);
    end
  endtask

  task automatic test_jumps();
    run_instr(6'd25, 0, 0, 1'b0);
    tests++;
    if (wb_pc_src !== 2'd2 || wb_reg_we !== 1'b1) begin
      fails++;
      $display("FAIL jal: pc_src=%0d reg_we=%0b, required 2/1", wb_pc_src, wb_reg_we);
    end
    run_instr(6'd26, 0, 0, 1'b0);
    tests++;
    if (wb_pc_src !== 2'd3 || wb_reg_we !== 1'b1 || n_cyc !== 4) begin
      fails++;
      $display("FAIL jalr: pc_src=%0d reg_we=%0b cycles=%0d, required 3/1/4", wb_pc_src, wb_reg_we, n_cyc);
    end
  endtask

  task automatic test_fetch_wait_nop();
    run_instr(6'd5, 2, 0, 1'b0);
    tests++;
    if (n_cyc !== 6 || cnt_imem !== 3 || cnt_ir !== 1 || cnt_dreq !== 0) begin
      fails++;
      $display("FAIL fetch_wait: cycles=%0d imem_req=%0d ir_write=%0d dmem_req=%0d, required 6/3/1/0",
               n_cyc, cnt_imem, cnt_ir, cnt_dreq);
    end
    run_instr(6'd0, 0, 0, 1'b0);
    tests++;
    if (n_cyc !== 4 || wb_reg_we !== 1'b0 || cnt_pcw !== 1 || instret !== exp_instret) begin
      fails++;
      $display("FAIL nop: cycles=%0d reg_we=%0b pcw=%0d instret=%0d, required 4/0/1/%0d",
               n_cyc, wb_reg_we, cnt_pcw, instret, exp_instret);
    end
  endtask

  task automatic test_illegal();
    int bad;
    bad = 0;
    uop_addr = 6'd63; imem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (state_q !== 3'd5 || trap !== 1'b1) begin
      fails++;
      $display("FAIL illegal_enter: state=%0d trap=%0b, required 5/1", state_q, trap);
    end
    dmem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({imem_req, ir_write, alu_en, dmem_req, dmem_we, reg_we, pc_write} !== 7'b0 ||
          trap !== 1'b1 || state_q !== 3'd5 || instret !== exp_instret)
        bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL trap_hold: %0d bad cycles of 20, required 0", bad);
    end
    #2 reset = 1'b1;
    #1;
    exp_instret = 0;
    tests++;
    if (state_q !== 3'd0 || trap !== 1'b0 || instret !== 32'd0) begin
      fails++;
      $display("FAIL trap_reset: state=%0d trap=%0b instret=%0d, required 0/0/0", state_q, trap, instret);
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    // 27 is the first illegal code above the legal range.
    uop_addr = 6'd27; imem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (state_q !== 3'd5 || trap !== 1'b1 || uop_q !== 6'd27) begin
      fails++;
      $display("FAIL illegal_27: state=%0d trap=%0b uop_q=%0d, required 5/1/27", state_q, trap, uop_q);
    end
    $display("[TB] illegal uop 63 and 27 trapped, state=%0d", state_q);
    #2 reset = 1'b1;
    imem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_async_reset();
    uop_addr = 6'd11; imem_ready = 1'b1; dmem_ready = 1'b0;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (state_q !== 3'd3 || dmem_req !== 1'b1) begin
      fails++;
      $display("FAIL async_pre: state=%0d dmem_req=%0b, required 3/1", state_q, dmem_req);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (state_q !== 3'd0 || dmem_req !== 1'b0 || imem_req !== 1'b0 || pc_write !== 1'b0 ||
        reg_we !== 1'b0 || instret !== 32'd0) begin
      fails++;
      $display("FAIL async_clear: state=%0d dreq=%0b ireq=%0b pcw=%0b regwe=%0b instret=%0d, required 0/0/0/0/0/0",
               state_q, dmem_req, imem_req, pc_write, reg_we, instret);
    end
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (state_q !== 3'd0 || imem_req !== 1'b1 || pc_write !== 1'b0 || instret !== 32'd0) begin
      fails++;
      $display("FAIL async_after: state=%0d imem_req=%0b pcw=%0b instret=%0d, required 0/1/0/0",
               state_q, imem_req, pc_write, instret);
    end
    $display("[TB] async reset during MEMORY wait, instret=%0d", instret);
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_store();
    test_branch();
    test_jumps();
    test_fetch_wait_nop();
    test_illegal();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 The block SHALL expose these ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- uop_addr  in  6  micro-operation address from the instruction decoder (0 = NOP, 1-26 = legal operations, 63 = illegal)
- imem_ready  in  1  instruction word available this cycle
- dmem_ready  in  1  data access complete this cycle
- branch_taken  in  1  branch comparison result, valid in EXECUTE
- imem_req  out  1  instruction fetch request
- ir_write  out  1  instruction register load strobe
- alu_en  out  1  ALU operation enable
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable
- reg_we  out  1  register file write enable
- pc_write  out  1  PC update strobe
- pc_src  out  2  next PC: 0 = PC+4, 1 = branch target, 2 = JAL target, 3 = JALR target
- uop_q  out  6  latched micro-operation address
- state_q  out  3  current state encoding
- trap  out  1  illegal-instruction halt flag
- instret  out  32  retired-instruction counter

Function
REQ-003 States and encodings SHALL be: FETCH = 0, DECODE = 1, EXECUTE = 2, MEMORY = 3, WRITEBACK = 4, TRAP = 5.
REQ-004 In FETCH:
- imem_req = 1 every cycle.
- Stay in FETCH while imem_ready = 0.
- When imem_ready = 1: ir_write = 1 in that same cycle (combinational), then go to DECODE.
REQ-005 In DECODE:
- uop_q <= uop_addr.
- Go to TRAP if uop_addr = 63 or uop_addr is in 27-62; otherwise go to EXECUTE.
REQ-006 In EXECUTE:
- alu_en = 1 for exactly one cycle.
- uop_q 11 (load) or 12 (store) -> MEMORY; all other uop_q values -> WRITEBACK.
- For uop_q = 13, branch_taken is sampled into a branch flag.
REQ-007 In MEMORY:
- dmem_req = 1 every cycle; dmem_we = 1 only when uop_q = 12.
- Stay in MEMORY while dmem_ready = 0.
- When dmem_ready = 1, go to WRITEBACK.
REQ-008 In WRITEBACK (single cycle):
- pc_write = 1, then go to FETCH.
- reg_we = 1 for uop_q in 1-11 and 14-26; reg_we = 0 for uop_q in 0, 12, 13.
REQ-009 pc_src in WRITEBACK SHALL be:
- 1 if uop_q = 13 and the branch flag is set;
- 2 if uop_q = 25;
- 3 if uop_q = 26;
- 0 otherwise.
REQ-010 Outside WRITEBACK, pc_src SHALL be 0 and pc_write and reg_we SHALL be 0.
REQ-011 All strobes (imem_req, ir_write, alu_en, dmem_req, dmem_we, reg_we, pc_write) SHALL be decoded from state_q alone, qualified only by the ready inputs and uop_q as stated.
REQ-012 instret SHALL increment by 1 on every WRITEBACK cycle and wrap from 0xFFFFFFFF to 0 without a flag.
REQ-013 TRAP SHALL be absorbing:
- trap = 1; all strobes = 0; instret frozen.
- Exit only by reset.
REQ-014 Ready inputs arriving outside their wait state (imem_ready outside FETCH, dmem_ready outside MEMORY) SHALL be ignored.
REQ-015 Cycle counts per instruction with zero wait states SHALL be:
- ALU, branch, jump, NOP: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
- Load, store: 5 cycles.
- Each wait cycle adds 1.

Reset
REQ-016 While reset = 1, independent of clk:
- state_q = FETCH; uop_q = 0; branch flag = 0; trap = 0; instret = 0.
- All strobes SHALL be 0, imem_req included.
REQ-017 After reset deasserts, imem_req SHALL assert in the first cycle.
REQ-018 Reset asserted mid-instruction (including during a MEMORY wait) SHALL abort the instruction with no pc_write and no reg_we.

Verification
REQ-019 ADD with zero waits: uop_addr = 1, imem_ready = 1 -> states 0,1,2,4,0; reg_we = 1 and pc_src = 0 in cycle 4; instret = 1.
REQ-020 Load with 3 dmem wait cycles: uop_addr = 11 -> dmem_req high for 4 cycles with dmem_we = 0; reg_we = 1 at WRITEBACK; 8 cycles total.
REQ-021 Store: uop_addr = 12 -> dmem_we = 1 throughout MEMORY; reg_we = 0 at WRITEBACK; pc_src = 0.
REQ-022 Branch and jumps:
- uop 13 with branch_taken = 1 -> pc_src = 1; with branch_taken = 0 -> pc_src = 0; reg_we = 0 in both cases.
- uop 25 -> pc_src = 2; uop 26 -> pc_src = 3; reg_we = 1 for both.
REQ-023 Illegal: uop_addr = 63 -> TRAP after DECODE; trap = 1; no strobes for 20 cycles; reset returns state_q = 0 and trap = 0.
REQ-024 Asynchronous reset during a MEMORY wait -> outputs clear before the next clk edge; no pc_write pulse; instret unchanged at 0.
